serial_word_comparator: RTL and testbench
=========================================

Name: serial_word_comparator

Overview:
- Parametrised, framed serial magnitude comparator. Consumes two operands DIGIT_W bits per beat over NUM_DIGITS beats and reports a registered less/equal/greater result once per word.
- Bit order is selectable per word: MSB-first or LSB-first.
- Generalises the single-bit serial comparators. Adds multi-bit digits, word framing, abort, and a result-valid strobe.
- Sits between serial links or bit-serial datapaths and the control logic that needs a word-level comparison.

Parameters:
- DIGIT_W, 1, bits of each operand consumed per accepted beat (>=1)
- NUM_DIGITS, 16, beats per word (>=1); word width = DIGIT_W*NUM_DIGITS

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  a_dig/b_dig carry a digit this cycle
- msb_first  input  1  1 = most significant digit first; sampled on the first beat of a word, ignored on later beats
- a_dig  input  DIGIT_W  digit of operand A
- b_dig  input  DIGIT_W  digit of operand B
- abort  input  1  synchronous discard of the word in progress
- busy  output  1  a word is partially received
- res_valid  output  1  one-cycle strobe, final result available
- res_less  output  1  A < B for the last completed word
- res_eq  output  1  A == B for the last completed word
- res_greater  output  1  A > B for the last completed word

Behaviour:
- Reset (async assert; deassert synchronous to clk):
  - busy=0, res_valid=0, res_eq=1, res_less=0, res_greater=0.
  - Digit counter=0; internal running state = equal.
- States:
  - IDLE (counter==0).
  - ACTIVE (0<counter<NUM_DIGITS).
  - busy = (state==ACTIVE).
- IDLE:
  - in_valid=1 → latch msb_first into the word-mode register, process the digit, counter=1.
  - If NUM_DIGITS==1, the word completes on this beat and the block stays in IDLE.
- ACTIVE:
  - Each in_valid beat processes one digit and increments the counter.
  - The beat that takes the counter to NUM_DIGITS completes the word; counter returns to 0 (IDLE).
  - in_valid=0 → hold all state. Gaps of any length are legal.
- Digit step (unsigned compare of a_dig vs b_dig gives lt/eq/gt; the running state is one of {LT, EQ, GT}):
  - MSB-first: if running==EQ, running takes the digit result; otherwise running is held. The first differing digit decides.
  - LSB-first: if the digit is not equal, running takes the digit result; otherwise running is held. The last differing digit decides.
  - The first beat of a word always starts from running=EQ, independent of the previous word.
- Completion:
  - Completing beat accepted in cycle t → in cycle t+1: res_valid=1 and res_less/eq/greater = final running state (exactly one-hot).
  - res_* hold until the next completion. res_valid is high for exactly one cycle.
- Back-to-back words: the first beat of the next word may be accepted in the cycle right after the completing beat. No bubble is required.
- abort:
  - abort=1 → counter=0, running=EQ, busy=0 next cycle. res_* are unchanged and no res_valid is generated.
  - abort with in_valid in the same cycle: abort wins and the digit is dropped.
  - abort in IDLE is a no-op.
- msb_first changing mid-word has no effect; the latched value governs the whole word.
- Async reset mid-word: all state returns to reset values immediately and the partial word is lost.

Optional Feature:
- Macro SERIAL_CMP_SIGNED_EN.
- Defined: adds input port is_signed (1 bit), sampled and latched with msb_first on the first beat. When latched 1, operands are two's complement: on the sign digit, the top bit of both a_dig and b_dig is inverted before the digit compare. The sign digit is the first beat when MSB-first and the NUM_DIGITS-th beat when LSB-first.
- Undefined: the port is absent and all comparisons are unsigned.

Test Plan:
- DIGIT_W=1, NUM_DIGITS=16, MSB-first: A=0x6482, B=0x6262 streamed MSB first → res_valid one cycle after beat 16, res_greater=1, res_less=0, res_eq=0.
- Same operands in LSB-first order (A bits 0x6482 LSB first) → res_greater=1. Then A=0x0001, B=0x8000 LSB-first → res_less=1.
- DIGIT_W=4, NUM_DIGITS=4: A=0xABCD, B=0xABCD with in_valid gaps of 0/3/1 cycles between beats → single res_valid, res_eq=1, busy low after the final beat.
- Back-to-back words A=5,B=9 then A=9,B=5 (DIGIT_W=4, NUM_DIGITS=2) with no idle cycle → consecutive res_valid strobes with less then greater.
- abort asserted together with beat 3 of a word → no res_valid, busy=0, previous res_* retained; a following full word A=B → res_eq=1.
- With SERIAL_CMP_SIGNED_EN, is_signed=1, DIGIT_W=8, NUM_DIGITS=2: A=0xFFFF(-1), B=0x0001 → res_less=1 in both MSB-first and LSB-first. With is_signed=0 → res_greater=1.

Source files
------------

// File: rtl/serial_word_comparator.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_comparator
// Purpose  : Framed serial magnitude comparator that consumes DIGIT_W-bit
//            digits for NUM_DIGITS beats and reports less/equal/greater per word.
//            Optional macro SERIAL_CMP_SIGNED_EN adds two's-complement compare.
// Revision : 1.0 - initial release
// ============================================================================
module serial_word_comparator #(
  parameter int DIGIT_W    = 1,
  parameter int NUM_DIGITS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               msb_first,
  input  logic [DIGIT_W-1:0] a_dig,
  input  logic [DIGIT_W-1:0] b_dig,
`ifdef SERIAL_CMP_SIGNED_EN
  input  logic               is_signed,
`endif
  input  logic               abort,
  output logic               busy,
  output logic               res_valid,
  output logic               res_less,
  output logic               res_eq,
  output logic               res_greater
);

  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  localparam logic [1:0] ST_EQ = 2'd0;
  localparam logic [1:0] ST_LT = 2'd1;
  localparam logic [1:0] ST_GT = 2'd2;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         run_q, run_d;
  logic               msb_q, msb_d;
  logic               res_valid_q, res_valid_d;
  logic               res_less_q, res_less_d;
  logic               res_eq_q, res_eq_d;
  logic               res_greater_q, res_greater_d;

  logic               first_beat;
  logic               last_beat;
  logic               mode_msb;
  logic [DIGIT_W-1:0] a_cmp;
  logic [DIGIT_W-1:0] b_cmp;
  logic [1:0]         dig_res;
  logic [1:0]         run_base;
  logic [1:0]         run_next;

  assign first_beat = (cnt_q == '0);
  assign last_beat  = (cnt_q == LAST_CNT);
  assign mode_msb   = first_beat ? msb_first : msb_q;

`ifdef SERIAL_CMP_SIGNED_EN
  localparam logic [DIGIT_W-1:0] TOP_MASK = DIGIT_W'(1) << (DIGIT_W - 1);

  logic sgn_q, sgn_d;
  logic sgn_eff;
  logic flip_top;

  // Inverting the sign bit maps two's-complement order onto unsigned order.
  assign sgn_eff  = first_beat ? is_signed : sgn_q;
  assign flip_top = sgn_eff & (mode_msb ? first_beat : last_beat);
  assign a_cmp    = a_dig ^ (flip_top ? TOP_MASK : '0);
  assign b_cmp    = b_dig ^ (flip_top ? TOP_MASK : '0);

  always_comb begin
    sgn_d = sgn_q;
    if (!abort && in_valid && first_beat) begin
      sgn_d = is_signed;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sgn_q <= 1'b0;
    end else begin
      sgn_q <= sgn_d;
    end
  end
`else
  assign a_cmp = a_dig;
  assign b_cmp = b_dig;
`endif

  always_comb begin
    dig_res  = ST_EQ;
    if (a_cmp < b_cmp) begin
      dig_res = ST_LT;
    end else if (a_cmp > b_cmp) begin
      dig_res = ST_GT;
    end
    run_base = first_beat ? ST_EQ : run_q;
    run_next = run_base;
    // MSB-first: first difference wins; LSB-first: last difference wins.
    if (mode_msb) begin
      if (run_base == ST_EQ) begin
        run_next = dig_res;
      end
    end else if (dig_res != ST_EQ) begin
      run_next = dig_res;
    end
  end

  always_comb begin
    cnt_d         = cnt_q;
    run_d         = run_q;
    msb_d         = msb_q;
    res_valid_d   = 1'b0;
    res_less_d    = res_less_q;
    res_eq_d      = res_eq_q;
    res_greater_d = res_greater_q;
    if (abort) begin
      cnt_d = '0;
      run_d = ST_EQ;
    end else if (in_valid) begin
      if (first_beat) begin
        msb_d = msb_first;
      end
      if (last_beat) begin
        cnt_d         = '0;
        run_d         = ST_EQ;
        res_valid_d   = 1'b1;
        res_less_d    = (run_next == ST_LT);
        res_eq_d      = (run_next == ST_EQ);
        res_greater_d = (run_next == ST_GT);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        run_d = run_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      run_q         <= ST_EQ;
      msb_q         <= 1'b0;
      res_valid_q   <= 1'b0;
      res_less_q    <= 1'b0;
      res_eq_q      <= 1'b1;
      res_greater_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      run_q         <= run_d;
      msb_q         <= msb_d;
      res_valid_q   <= res_valid_d;
      res_less_q    <= res_less_d;
      res_eq_q      <= res_eq_d;
      res_greater_q <= res_greater_d;
    end
  end

  assign busy        = (cnt_q != '0);
  assign res_valid   = res_valid_q;
  assign res_less    = res_less_q;
  assign res_eq      = res_eq_q;
  assign res_greater = res_greater_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_comparator.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_word_comparator
// Purpose  : Randomised self-checking bench with a word-level compare model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_word_comparator;

  localparam int DW = 4;
  localparam int ND = 4;
  localparam int W  = DW * ND;
`ifdef SERIAL_CMP_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          msb_first;
  logic [DW-1:0] a_dig;
  logic [DW-1:0] b_dig;
  logic          is_signed;
  logic          abort;
  logic          busy;
  logic          res_valid;
  logic          res_less;
  logic          res_eq;
  logic          res_greater;

  int checks = 0;
  int errors = 0;

  // Expected outputs, maintained at word level by the stimulus tasks.
  logic exp_busy, exp_valid;
  logic [2:0] exp_res;
  logic chk_en = 1'b0;
  int fixed_gap[ND];
  bit use_fixed_gap = 1'b0;

  serial_word_comparator #(.DIGIT_W(DW), .NUM_DIGITS(ND)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .msb_first  (msb_first),
    .a_dig      (a_dig),
    .b_dig      (b_dig),
`ifdef SERIAL_CMP_SIGNED_EN
    .is_signed  (is_signed),
`endif
    .abort      (abort),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_less   (res_less),
    .res_eq     (res_eq),
    .res_greater(res_greater)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // {less, eq, greater} for whole-word operands.
  function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic s);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    if (s) return (sa < sb) ? 3'b100 : (sa == sb) ? 3'b010 : 3'b001;
    return (a < b) ? 3'b100 : (a == b) ? 3'b010 : 3'b001;
  endfunction

  task automatic check1(input string name, input logic [2:0] act, input logic [2:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %b required %b at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      check1("busy", {2'b0, busy}, {2'b0, exp_busy});
      check1("res_valid", {2'b0, res_valid}, {2'b0, exp_valid});
      check1("res_lt_eq_gt", {res_less, res_eq, res_greater}, exp_res);
    end
  end

  // One clock: present inputs, take the edge, settle just past it.
  task automatic step(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic m, input logic s, input logic ab);
    in_valid  = v;
    a_dig     = a;
    b_dig     = b;
    msb_first = m;
    is_signed = s;
    abort     = ab;
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                           input logic s, input int max_gap, input int abort_at);
    int idx;
    int g;
    for (int i = 0; i < ND; i++) begin
      g = use_fixed_gap ? fixed_gap[i] : ((max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
      for (int k = 0; k < g; k++) begin
        step(1'b0, DW'($urandom), DW'($urandom), ~m, ~s, 1'b0);
      end
      idx = m ? (ND - 1 - i) : i;
      step(1'b1, a[DW*idx +: DW], b[DW*idx +: DW],
           (i == 0) ? m : 1'($urandom), (i == 0) ? s : 1'($urandom), (i == abort_at));
      if (i == abort_at) begin
        exp_busy = 1'b0;
        return;
      end
      if (i == ND - 1) begin
        exp_busy  = 1'b0;
        exp_valid = 1'b1;
        exp_res   = model(a, b, s & SIGNED_EN);
      end else begin
        exp_busy = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rm;
    logic rs;
    rst = 1'b1;
    in_valid = 1'b0; a_dig = '0; b_dig = '0; msb_first = 1'b0; is_signed = 1'b0; abort = 1'b0;
    exp_busy = 1'b0; exp_valid = 1'b0; exp_res = 3'b010;
    repeat (3) @(posedge clk);
    #1;
    check1("reset_busy_valid", {1'b0, busy, res_valid}, 3'b000);
    check1("reset_res", {res_less, res_eq, res_greater}, 3'b010);
    rst = 1'b0;
    chk_en = 1'b1;
    idle(2);

    send_word(16'h6482, 16'h6262, 1'b1, 1'b0, 0, -1);
    check1("msb_6482_gt", {res_valid, res_less, res_greater}, 3'b101);
    send_word(16'h6482, 16'h6262, 1'b0, 1'b0, 1, -1);
    check1("lsb_6482_gt", {res_valid, res_less, res_greater}, 3'b101);
    idle(1);
    send_word(16'h0001, 16'h8000, 1'b0, 1'b0, 0, -1);
    check1("lsb_0001_lt", {res_less, res_eq, res_greater}, 3'b100);

    fixed_gap = '{0, 0, 3, 1};
    use_fixed_gap = 1'b1;
    send_word(16'hABCD, 16'hABCD, 1'b1, 1'b0, 0, -1);
    use_fixed_gap = 1'b0;
    check1("gap_eq", {busy, res_valid, res_eq}, 3'b011);

    send_word(16'd5, 16'd9, 1'b1, 1'b0, 0, -1);
    check1("b2b_lt", {res_valid, res_less, res_greater}, 3'b110);
    send_word(16'd9, 16'd5, 1'b1, 1'b0, 0, -1);
    check1("b2b_gt", {res_valid, res_less, res_greater}, 3'b101);

    send_word(16'h1234, 16'h0234, 1'b1, 1'b0, 0, 2);
    check1("abort_retain", {busy, res_valid, res_greater}, 3'b001);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check1("abort_idle", {busy, res_valid, res_greater}, 3'b001);
    send_word(16'h4321, 16'h4321, 1'b0, 1'b0, 0, -1);
    check1("after_abort_eq", {res_valid, res_eq, res_greater}, 3'b110);

    if (SIGNED_EN) begin
      send_word(16'hFFFF, 16'h0001, 1'b1, 1'b1, 0, -1);
      check1("signed_msb_lt", {res_less, res_eq, res_greater}, 3'b100);
      send_word(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1, -1);
      check1("signed_lsb_lt", {res_less, res_eq, res_greater}, 3'b100);
      send_word(16'hFFFF, 16'h0001, 1'b1, 1'b0, 0, -1);
      check1("unsigned_gt", {res_less, res_eq, res_greater}, 3'b001);
    end

    // Asynchronous reset partway through a word.
    send_word(16'h1111, 16'h2222, 1'b1, 1'b0, 0, -1);
    step(1'b1, 4'h3, 4'h1, 1'b1, 1'b0, 1'b0);
    exp_busy = 1'b1;
    step(1'b1, 4'h3, 4'h1, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check1("async_rst", {busy, res_valid, res_eq}, 3'b001);
    check1("async_rst_res", {res_less, res_eq, res_greater}, 3'b010);
    in_valid = 1'b0; abort = 1'b0;
    exp_busy = 1'b0; exp_valid = 1'b0; exp_res = 3'b010;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    for (int n = 0; n < 400; n++) begin
      ra = W'($urandom);
      rb = ($urandom_range(3, 0) == 0) ? ra : W'($urandom);
      if ($urandom_range(2, 0) == 0) rb = ra ^ (W'(1) << $urandom_range(W - 1, 0));
      rm = 1'($urandom);
      rs = SIGNED_EN ? 1'($urandom) : 1'b0;
      send_word(ra, rb, rm, rs, ($urandom_range(1, 0) == 1) ? 2 : 0,
                ($urandom_range(9, 0) == 0) ? int'($urandom_range(ND - 1, 0)) : -1);
      if ($urandom_range(7, 0) == 0) step(1'b0, '0, '0, 1'b0, 1'b0, 1'($urandom));
    end
    idle(2);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
